// File: rtl/compress_ctrl_pkg.sv
// compress_ctrl_pkg
// Shared definitions for the compression line sequencer: the controller state
// encoding, the width of one encoded-length field, and the helper that sizes
// the running total so the worst-case line (every word at WORD_SIZE+2 bits)
// cannot wrap.
package compress_ctrl_pkg;

  localparam int LEN_W = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  // Bits needed to hold the sum of all encoded lengths of one line.
  function automatic int calc_tot_w(input int cache_line, input int word_size);
    int num_pairs;
    num_pairs = cache_line / (2 * word_size);
    return $clog2(2 * num_pairs * (word_size + 2) + 1);
  endfunction

endpackage

// File: rtl/seq_len_accumulator.sv
// seq_len_accumulator
// Tracks the pairs in flight through the match/length datapath and sums the
// encoded lengths they return.
//   clk, srst          : clock, synchronous active-high reset
//   clear_line         : start of a new line; zero count and total
//   clear_outstanding  : forget in-flight pairs (early abort)
//   issue              : a pair was handed to the datapath this cycle
//   len_valid          : lengths for one pair are presented this cycle
//   len1, len2         : encoded bit lengths of the low/high word
//   outstanding        : pairs issued but not yet returned
//   total              : accumulated encoded size in bits
//   overflow           : total exceeds the raw line size
module seq_len_accumulator
  import compress_ctrl_pkg::*;
#(
  parameter int CACHE_LINE = 512,
  parameter int WORD_SIZE  = 32,
  parameter int CNT_W      = 4,
  parameter int TOT_W      = 10
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             clear_line,
  input  logic             clear_outstanding,
  input  logic             issue,
  input  logic             len_valid,
  input  logic [LEN_W-1:0] len1,
  input  logic [LEN_W-1:0] len2,
  output logic [CNT_W-1:0] outstanding,
  output logic [TOT_W-1:0] total,
  output logic             overflow
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(WORD_SIZE + 2);

  logic [LEN_W-1:0] len1_sat;
  logic [LEN_W-1:0] len2_sat;
  logic             ret;
  logic [CNT_W-1:0] outstanding_reg, outstanding_next;
  logic [TOT_W-1:0] total_reg, total_next;

  always_comb begin
    len1_sat         = (len1 > LEN_MAX) ? LEN_MAX : len1;
    len2_sat         = (len2 > LEN_MAX) ? LEN_MAX : len2;
    // A return with nothing in flight is stray (e.g. from before a reset).
    ret              = len_valid && (outstanding_reg != '0);
    outstanding_next = outstanding_reg;
    total_next       = total_reg;
    if (issue && !ret) begin
      outstanding_next = outstanding_reg + CNT_W'(1);
    end else if (!issue && ret) begin
      outstanding_next = outstanding_reg - CNT_W'(1);
    end
    if (ret) begin
      total_next = total_reg + TOT_W'(len1_sat) + TOT_W'(len2_sat);
    end
    if (clear_outstanding) begin
      outstanding_next = '0;
    end
    if (clear_line) begin
      outstanding_next = '0;
      total_next       = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      outstanding_reg <= '0;
      total_reg       <= '0;
    end else begin
      outstanding_reg <= outstanding_next;
      total_reg       <= total_next;
    end
  end

  assign outstanding = outstanding_reg;
  assign total       = total_reg;
  assign overflow    = (total_reg > TOT_W'(CACHE_LINE));

endmodule

// File: rtl/compress_line_sequencer.sv
// compress_line_sequencer
// Accepts one cache line, issues it as word pairs to the match/length
// datapath, sums the returned encoded lengths and reports whether the line is
// stored compressed (o_comp_bits = total) or raw (o_comp_bits = CACHE_LINE).
// Ports:
//   i_clk, i_reset               : clock, synchronous active-high reset
//   i_line_valid/i_line/o_line_ready : line input handshake
//   o_pair_valid/o_pair/i_pair_ready : pair issue handshake
//   o_first_pair, o_last_pair    : mark pair 0 / last pair of the line
//   i_len_valid, i_len1, i_len2  : per-pair encoded lengths, issue order
//   o_flush                      : one-cycle datapath discard pulse
//   o_done_valid/o_comp_bits/o_uncompressed/i_done_ready : result handshake
// Build option: COMPRESS_EARLY_ABORT_EN stops issuing as soon as the total
// exceeds the line size, flushes the datapath and reports the line raw.
// Without it every pair is issued and drained and o_flush is held low.
module compress_line_sequencer
  import compress_ctrl_pkg::*;
#(
  parameter  int CACHE_LINE = 512,
  parameter  int WORD_SIZE  = 32,
  localparam int PAIR_W     = 2 * WORD_SIZE,
  localparam int NUM_PAIRS  = CACHE_LINE / PAIR_W,
  localparam int TOT_W      = calc_tot_w(CACHE_LINE, WORD_SIZE)
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_line_valid,
  input  logic [CACHE_LINE-1:0] i_line,
  output logic                  o_line_ready,
  output logic                  o_pair_valid,
  output logic [PAIR_W-1:0]     o_pair,
  output logic                  o_first_pair,
  output logic                  o_last_pair,
  input  logic                  i_pair_ready,
  input  logic                  i_len_valid,
  input  logic [LEN_W-1:0]      i_len1,
  input  logic [LEN_W-1:0]      i_len2,
  output logic                  o_flush,
  output logic                  o_done_valid,
  output logic [TOT_W-1:0]      o_comp_bits,
  output logic                  o_uncompressed,
  input  logic                  i_done_ready
);

  localparam int IDX_W = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;
  localparam int CNT_W = $clog2(NUM_PAIRS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PAIRS - 1);

  seq_state_t        state_reg, state_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic [CACHE_LINE-1:0] line_reg;
  logic [PAIR_W-1:0] pair_arr [NUM_PAIRS];
  logic [PAIR_W-1:0] pair_reg;
  logic              line_ready_reg, pair_valid_reg, first_reg, last_reg;
  logic              done_valid_reg, uncompressed_reg;
  logic [TOT_W-1:0]  comp_bits_reg;
  logic              accept, pair_hs, abort;
  logic [CNT_W-1:0]  outstanding;
  logic [TOT_W-1:0]  total;
  logic              overflow;
  logic [TOT_W-1:0]  result_bits;

  for (genvar gi = 0; gi < NUM_PAIRS; gi++) begin : g_pair
    assign pair_arr[gi] = line_reg[gi*PAIR_W +: PAIR_W];
  end

  seq_len_accumulator #(
    .CACHE_LINE (CACHE_LINE),
    .WORD_SIZE  (WORD_SIZE),
    .CNT_W      (CNT_W),
    .TOT_W      (TOT_W)
  ) u_acc (
    .clk               (i_clk),
    .srst              (i_reset),
    .clear_line        (accept),
    .clear_outstanding (abort),
    .issue             (pair_hs),
    .len_valid         (i_len_valid && (state_reg != IDLE)),
    .len1              (i_len1),
    .len2              (i_len2),
    .outstanding       (outstanding),
    .total             (total),
    .overflow          (overflow)
  );

  assign result_bits = overflow ? TOT_W'(CACHE_LINE) : total;

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    accept     = 1'b0;
    pair_hs    = 1'b0;
    abort      = 1'b0;
`ifdef COMPRESS_EARLY_ABORT_EN
    if (((state_reg == ISSUE) || (state_reg == DRAIN)) && overflow) begin
      abort = 1'b1;
    end
`endif
    case (state_reg)
      IDLE: begin
        if (line_ready_reg && i_line_valid) begin
          accept     = 1'b1;
          idx_next   = '0;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (abort) begin
          state_next = DONE;
        end else if (pair_valid_reg && i_pair_ready) begin
          pair_hs = 1'b1;
          if (idx_reg == LAST_IDX) begin
            state_next = DRAIN;
          end else begin
            idx_next = idx_reg + IDX_W'(1);
          end
        end
      end
      DRAIN: begin
        if (abort) begin
          state_next = DONE;
        end else if (outstanding == '0) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (done_valid_reg && i_done_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Control outputs are registered from the next state so each one lines up
  // with the state it describes.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg        <= IDLE;
      idx_reg          <= '0;
      line_ready_reg   <= 1'b0;
      pair_valid_reg   <= 1'b0;
      first_reg        <= 1'b0;
      last_reg         <= 1'b0;
      done_valid_reg   <= 1'b0;
      comp_bits_reg    <= '0;
      uncompressed_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      idx_reg          <= idx_next;
      line_ready_reg   <= (state_next == IDLE);
      pair_valid_reg   <= (state_next == ISSUE);
      first_reg        <= (state_next == ISSUE) && (idx_next == '0);
      last_reg         <= (state_next == ISSUE) && (idx_next == LAST_IDX);
      done_valid_reg   <= (state_next == DONE);
      comp_bits_reg    <= (state_next == DONE) ? result_bits : '0;
      uncompressed_reg <= (state_next == DONE) && overflow;
    end
  end

  // Data path registers carry no reset; they are qualified by the valids.
  // Pair 0 comes straight from the input because line_reg loads on the same
  // edge.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      line_reg <= i_line;
      pair_reg <= i_line[PAIR_W-1:0];
    end else if (pair_hs && (state_next == ISSUE)) begin
      pair_reg <= pair_arr[idx_next];
    end
  end

`ifdef COMPRESS_EARLY_ABORT_EN
  logic flush_reg;
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      flush_reg <= 1'b0;
    end else begin
      flush_reg <= abort;
    end
  end
  assign o_flush = flush_reg;
`else
  assign o_flush = 1'b0;
`endif

  assign o_line_ready   = line_ready_reg;
  assign o_pair_valid   = pair_valid_reg;
  assign o_pair         = pair_reg;
  assign o_first_pair   = first_reg;
  assign o_last_pair    = last_reg;
  assign o_done_valid   = done_valid_reg;
  assign o_comp_bits    = comp_bits_reg;
  assign o_uncompressed = uncompressed_reg;

endmodule

// File: tb/tb_compress_line_sequencer.sv
// tb_compress_line_sequencer
// Directed bench for compress_line_sequencer (512-bit line, 32-bit words,
// 8 pairs). A small datapath model returns fixed lengths a fixed number of
// cycles after each pair handshake.
module tb_compress_line_sequencer;

  localparam int CL = 512;
  localparam int NP = 8;
  localparam int TW = 10;

  logic          clk;
  logic          i_reset;
  logic          i_line_valid;
  logic [CL-1:0] i_line;
  logic          o_line_ready;
  logic          o_pair_valid;
  logic [63:0]   o_pair;
  logic          o_first_pair;
  logic          o_last_pair;
  logic          i_pair_ready;
  logic          i_len_valid;
  logic [5:0]    i_len1;
  logic [5:0]    i_len2;
  logic          o_flush;
  logic          o_done_valid;
  logic [TW-1:0] o_comp_bits;
  logic          o_uncompressed;
  logic          i_done_ready;

  compress_line_sequencer #(.CACHE_LINE(CL), .WORD_SIZE(32)) dut (
    .i_clk          (clk),
    .i_reset        (i_reset),
    .i_line_valid   (i_line_valid),
    .i_line         (i_line),
    .o_line_ready   (o_line_ready),
    .o_pair_valid   (o_pair_valid),
    .o_pair         (o_pair),
    .o_first_pair   (o_first_pair),
    .o_last_pair    (o_last_pair),
    .i_pair_ready   (i_pair_ready),
    .i_len_valid    (i_len_valid),
    .i_len1         (i_len1),
    .i_len2         (i_len2),
    .o_flush        (o_flush),
    .o_done_valid   (o_done_valid),
    .o_comp_bits    (o_comp_bits),
    .o_uncompressed (o_uncompressed),
    .i_done_ready   (i_done_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- datapath model and monitors ----------------
  int          lat = 1;
  logic        dp_en = 1'b1;
  logic        man_len_valid = 1'b0;
  logic        dp_len_valid = 1'b0;
  logic [15:0] pipe = '0;
  logic        toggle_en = 1'b0;
  logic        tog_q = 1'b1;
  logic        mon_clr = 1'b0;
  int          log_n = 0;
  logic [63:0] log_pair [16];
  logic [1:0]  log_fl [16];
  int          max_out = 0;
  int          flush_cnt = 0;

  assign i_len_valid  = dp_en ? dp_len_valid : man_len_valid;
  assign i_pair_ready = tog_q;

  always @(posedge clk) begin
    logic hs;
    logic rst_s;
    hs    = o_pair_valid && i_pair_ready;
    rst_s = i_reset;
    if (mon_clr) begin
      log_n     = 0;
      max_out   = 0;
      flush_cnt = 0;
    end else begin
      if (hs && log_n < 16) begin
        log_pair[log_n] = o_pair;
        log_fl[log_n]   = {o_first_pair, o_last_pair};
        log_n++;
      end
      if (int'(dut.u_acc.outstanding_reg) > max_out) max_out = int'(dut.u_acc.outstanding_reg);
      if (o_flush) flush_cnt++;
    end
    #1;
    if (rst_s || !dp_en) pipe = '0;
    else pipe = {pipe[14:0], hs};
    dp_len_valid = pipe[lat-1];
    tog_q = toggle_en ? ~tog_q : 1'b1;
  end

  // ---------------- helpers ----------------
  task automatic clear_monitors();
    mon_clr = 1'b1;
    @(posedge clk); #1;
    mon_clr = 1'b0;
  endtask

  task automatic run_line(input logic [CL-1:0] line, output int k);
    int n;
    i_line       = line;
    i_line_valid = 1'b1;
    n = 0;
    while (o_line_ready !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    i_line_valid = 1'b0;
    k = 0;
    while (o_done_valid !== 1'b1 && k < 300) begin
      @(posedge clk); #1; k++;
    end
    check("done_seen", o_done_valid, 1'b1);
    $display("line done after %0d cycles: comp_bits=%0d uncompressed=%0d",
             k, o_comp_bits, o_uncompressed);
  endtask

  task automatic release_done();
    i_done_ready = 1'b1;
    @(posedge clk); #1;
    i_done_ready = 1'b0;
  endtask

  logic [CL-1:0] line_a;
  int            k;

  initial begin
    i_reset      = 1'b1;
    i_line_valid = 1'b0;
    i_line       = '0;
    i_len1       = 6'd2;
    i_len2       = 6'd2;
    i_done_ready = 1'b0;
    for (int p = 0; p < NP; p++) begin
      line_a[p*64 +: 64] = {32'hA000_0000 + 32'(2*p + 1), 32'hA000_0000 + 32'(2*p)};
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_line_ready", o_line_ready, 1'b0);
    check("rst_outputs",
          {o_pair_valid, o_first_pair, o_last_pair, o_flush, o_done_valid, o_uncompressed, o_comp_bits},
          '0);
    i_reset = 1'b0;
    @(posedge clk); #1;
    check("ready_after_rst", o_line_ready, 1'b1);
    check("pv_after_rst", o_pair_valid, 1'b0);

    // All lengths 2, latency 1: 8*4 = 32 bits, done 10 edges after accept
    lat = 1; i_len1 = 6'd2; i_len2 = 6'd2;
    run_line(line_a, k);
    check("zero_latency", k, 10);
    check("zero_bits", o_comp_bits, 32);
    check("zero_unc", o_uncompressed, 1'b0);
    release_done();
    check("zero_ready_next", o_line_ready, 1'b1);

    // All lengths 34: 544 > 512 -> raw
    clear_monitors();
    i_len1 = 6'd34; i_len2 = 6'd34;
    run_line(line_a, k);
    check("ovf_bits", o_comp_bits, 512);
    check("ovf_unc", o_uncompressed, 1'b1);
`ifdef COMPRESS_EARLY_ABORT_EN
    check("ovf_flush", flush_cnt, 1);
`else
    check("ovf_flush", flush_cnt, 0);
`endif
    release_done();

    // Exactly 512 is not an overflow
    i_len1 = 6'd32; i_len2 = 6'd32;
    run_line(line_a, k);
    check("edge512_bits", o_comp_bits, 512);
    check("edge512_unc", o_uncompressed, 1'b0);
    release_done();

    // Saturation: 63 -> 34, 0 stays 0: 8*34 = 272
    i_len1 = 6'd63; i_len2 = 6'd0;
    run_line(line_a, k);
    check("sat_bits", o_comp_bits, 272);
    check("sat_unc", o_uncompressed, 1'b0);
    release_done();

    // Ready toggling: each pair exactly once, in order, flags on ends only
    clear_monitors();
    toggle_en = 1'b1;
    i_len1 = 6'd5; i_len2 = 6'd7;
    run_line(line_a, k);
    toggle_en = 1'b0;
    check("tog_bits", o_comp_bits, 96);
    check("tog_count", log_n, NP);
    for (int p = 0; p < NP; p++) begin
      check($sformatf("tog_pair%0d", p), log_pair[p], line_a[p*64 +: 64]);
      check($sformatf("tog_flags%0d", p), log_fl[p], {p == 0, p == NP - 1});
    end
    release_done();

    // Latency 3, all 10 -> 160; outstanding peaks at 3; hold result 5 cycles
    clear_monitors();
    lat = 3; i_len1 = 6'd10; i_len2 = 6'd10;
    run_line(line_a, k);
    check("lat3_bits", o_comp_bits, 160);
    check("lat3_max_out", max_out, 3);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check($sformatf("hold%0d", c),
            {o_done_valid, o_line_ready, o_uncompressed, o_comp_bits},
            {1'b1, 1'b0, 1'b0, 10'd160});
    end
    release_done();
    check("hold_release_ready", o_line_ready, 1'b1);
    check("hold_release_done", o_done_valid, 1'b0);

    // Reset in DRAIN with 2 outstanding, then stray returns
    i_line = line_a; i_line_valid = 1'b1;
    @(posedge clk); #1;          // o_line_ready is high here; accepted at this edge
    i_line_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("mid_outstanding", dut.u_acc.outstanding_reg, 2);
    check("mid_pv_low", o_pair_valid, 1'b0);
    i_reset = 1'b1;
    @(posedge clk); #1;
    dp_en   = 1'b0;
    i_reset = 1'b0;
    check("mid_rst_outputs",
          {o_line_ready, o_pair_valid, o_first_pair, o_last_pair, o_flush, o_done_valid, o_uncompressed, o_comp_bits},
          '0);
    man_len_valid = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    man_len_valid = 1'b0;
    check("stray_total", dut.u_acc.total_reg, 0);
    check("stray_outstanding", dut.u_acc.outstanding_reg, 0);
    check("stray_ready", o_line_ready, 1'b1);
    dp_en = 1'b1;

    // Next line after reset: latency 2, lengths 3/4 -> 56
    lat = 2; i_len1 = 6'd3; i_len2 = 6'd4;
    run_line(line_a, k);
    check("post_rst_bits", o_comp_bits, 56);
    check("post_rst_unc", o_uncompressed, 1'b0);
    release_done();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
